// File: rtl/pagerank_iter_ctrl_pkg.sv
// pagerank_pkg: shared state encoding and fixed-point constants for the PageRank iteration controller.
package pagerank_pkg;
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_SNAP, S_STEP, S_CHECK, S_DONE} state_t;
    localparam int WIDTH_D = 16;
    localparam logic [16:0] ONE_Q16 = 17'h10000;
    localparam logic [15:0] DAMP = 16'h2666;
    function automatic logic [15:0] init_val(input int n);
        return 16'(ONE_Q16 / 17'(n));
    endfunction
    localparam logic [15:0] INIT_VAL = init_val(4);
endpackage

// File: rtl/pagerank_iter_ctrl_if.sv
// pagerank_iter_ctrl_if: host control, datapath strobes and node value bus of the iteration controller.
interface pagerank_iter_ctrl_if #(
    parameter int N      = 4,
    parameter int WIDTH  = 16,
    parameter int ITER_W = 8
);
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  tol;
    logic [ITER_W-1:0] max_iter;
    logic [N*WIDTH-1:0] dp_vals;
    logic              dp_init;
    logic              dp_step;
    logic              busy;
    logic              done;
    logic              converged;
    logic [ITER_W-1:0] iter_count;
    logic [WIDTH-1:0]  max_delta;
    modport master (
        output start, abort, tol, max_iter, dp_vals,
        input  dp_init, dp_step, busy, done, converged, iter_count, max_delta
    );
    modport slave (
        input  start, abort, tol, max_iter, dp_vals,
        output dp_init, dp_step, busy, done, converged, iter_count, max_delta
    );
endinterface

// File: rtl/pagerank_delta_max.sv
// pagerank_delta_max: |cur - prev| with a running maximum across the nodes of one iteration.
module pagerank_delta_max #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_tol,
    output logic [WIDTH-1:0] o_max,
    output logic             o_within
);
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] w_d;
    assign w_d      = (i_cur >= i_prev) ? i_cur - i_prev : i_prev - i_cur;
    // o_max already includes the node being checked this cycle
    assign o_max    = (i_clr || w_d > r_max) ? w_d : r_max;
    assign o_within = o_max <= i_tol;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_max <= '0;
        else if (i_en) r_max <= o_max;
    end
endmodule

// File: rtl/pagerank_iter_ctrl.sv
// pagerank_iter_ctrl: sequences init/step strobes of the rank datapath and detects convergence
// by serially comparing every node against the snapshot of the previous iteration.
module pagerank_iter_ctrl
    import pagerank_pkg::*;
#(
    parameter int N          = 4,
    parameter int WIDTH      = WIDTH_D,
    parameter int DP_LAT     = 1,
    parameter int ITER_W     = 8,
    parameter int CONV_COUNT = 2
) (
    input logic clk,
    input logic rst_n,
    pagerank_iter_ctrl_if.slave bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam int SW = $clog2(CONV_COUNT + 1);
    state_t            r_state;
    logic              r_tag_step;
    logic [CW-1:0]     r_cnt;
    logic [KW-1:0]     r_k;
    logic [SW-1:0]     r_stable;
    logic [WIDTH-1:0]  r_tol;
    logic [ITER_W-1:0] r_max_iter;
    logic [WIDTH-1:0]  r_prev [N];
    logic              r_dp_init, r_dp_step, r_busy, r_done, r_conv;
    logic [ITER_W-1:0] r_iter;
    logic [WIDTH-1:0]  r_max_delta;
    logic [WIDTH-1:0]  w_cur, w_run_max;
    logic              w_within;
    logic [SW-1:0]     w_stable_nxt;
    logic [ITER_W-1:0] w_iter_nxt;
    assign w_cur        = bus.dp_vals[r_k*WIDTH +: WIDTH];
    assign w_stable_nxt = w_within ? r_stable + 1'b1 : '0;
    assign w_iter_nxt   = r_iter + 1'b1;
    pagerank_delta_max #(.WIDTH(WIDTH)) u_dmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (r_state == S_CHECK),
        .i_clr    (r_k == '0),
        .i_cur    (w_cur),
        .i_prev   (r_prev[r_k]),
        .i_tol    (r_tol),
        .o_max    (w_run_max),
        .o_within (w_within)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tag_step  <= 1'b0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_stable    <= '0;
            r_tol       <= '0;
            r_max_iter  <= '0;
            for (int i = 0; i < N; i++) r_prev[i] <= '0;
            r_dp_init   <= 1'b0;
            r_dp_step   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_conv      <= 1'b0;
            r_iter      <= '0;
            r_max_delta <= '0;
        end else begin
            r_dp_init <= 1'b0;
            r_dp_step <= 1'b0;
            r_done    <= 1'b0;
            if (bus.abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_conv  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (bus.start) begin
                        r_state     <= S_INIT;
                        r_dp_init   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_tol       <= bus.tol;
                        r_max_iter  <= bus.max_iter;
                        r_iter      <= '0;
                        r_conv      <= 1'b0;
                        r_max_delta <= '0;
                        r_stable    <= '0;
                    end
                    S_INIT: begin
                        r_state    <= S_WAIT;
                        r_tag_step <= 1'b0;
                        r_cnt      <= '0;
                    end
                    S_WAIT: if (r_cnt == CW'(DP_LAT - 1)) begin
                        r_state <= r_tag_step ? S_CHECK : S_SNAP;
                        r_k     <= '0;
                    end else r_cnt <= r_cnt + 1'b1;
                    S_SNAP: begin
                        for (int i = 0; i < N; i++) r_prev[i] <= bus.dp_vals[i*WIDTH +: WIDTH];
                        r_state   <= (r_max_iter == '0) ? S_DONE : S_STEP;
                        r_done    <= (r_max_iter == '0);
                        r_dp_step <= (r_max_iter != '0);
                    end
                    S_STEP: begin
                        r_state    <= S_WAIT;
                        r_tag_step <= 1'b1;
                        r_cnt      <= '0;
                    end
                    S_CHECK: begin
                        r_prev[r_k] <= w_cur;
                        r_k         <= r_k + 1'b1;
                        // last node closes the iteration: convergence beats the iteration cap
                        if (r_k == KW'(N - 1)) begin
                            r_iter      <= w_iter_nxt;
                            r_max_delta <= w_run_max;
                            r_stable    <= w_stable_nxt;
                            if (w_stable_nxt == SW'(CONV_COUNT)) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_conv  <= 1'b1;
                            end else if (w_iter_nxt == r_max_iter) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= S_STEP;
                                r_dp_step <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
    assign bus.dp_init    = r_dp_init;
    assign bus.dp_step    = r_dp_step;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.converged  = r_conv;
    assign bus.iter_count = r_iter;
    assign bus.max_delta  = r_max_delta;
endmodule

// File: tb/tb_pagerank_iter_ctrl.sv
// tb_pagerank_iter_ctrl: table-driven and randomized checks of the iteration controller
// against a scripted datapath and an iteration-level reference model.
module tb_pagerank_iter_ctrl;
    import pagerank_pkg::*;
    localparam int N = 4, W = 16, DP_LAT = 1, IW = 8, CC = 2, MAXS = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pagerank_iter_ctrl_if #(.N(N), .WIDTH(W), .ITER_W(IW)) bus ();
    pagerank_iter_ctrl #(.N(N), .WIDTH(W), .DP_LAT(DP_LAT), .ITER_W(IW), .CONV_COUNT(CC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    typedef struct {
        int         mode;
        logic [15:0] tol;
        logic [7:0]  mi;
        int         extra_start;
        logic       conv;
        int         iters;
        logic [15:0] maxd;
    } vec_t;
    vec_t tbl [7];
    logic [W-1:0] seq [MAXS][N];
    int checks = 0, errors = 0, spread = 0, sidx = 0;
    int o_done, o_init, o_step1, o_nsteps;
    logic o_conv;
    logic [IW-1:0] o_iter;
    logic [W-1:0] o_maxd;
    // scripted datapath: node values after init / after each step come from seq[]
    function automatic logic [N*W-1:0] pack(input int it);
        logic [N*W-1:0] p;
        for (int n = 0; n < N; n++) p[n*W +: W] = seq[it][n];
        return p;
    endfunction
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.dp_vals <= '0;
            sidx <= 0;
        end else if (bus.dp_init) begin
            bus.dp_vals <= pack(0);
            sidx <= 0;
        end else if (bus.dp_step) begin
            bus.dp_vals <= pack((sidx + 1 < MAXS) ? sidx + 1 : MAXS - 1);
            sidx <= sidx + 1;
        end
    end
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic fill(input int mode);
        int v;
        for (int n = 0; n < N; n++) seq[0][n] = INIT_VAL;
        for (int it = 1; it < MAXS; it++)
            for (int n = 0; n < N; n++) begin
                v = int'(seq[it-1][n]);
                if (mode == 1) v = (n == 2 && it % 2 == 1) ? int'(INIT_VAL) + 'h100 : int'(INIT_VAL);
                else if (mode == 2 && $urandom_range(0, 2) != 0) v = v + int'($urandom_range(0, 2 * spread)) - spread;
                seq[it][n] = 16'(v);
            end
    endtask
    // iteration-level reference: max |delta| per iteration, stable streak, cap
    task automatic model(input logic [15:0] t, input logic [7:0] mi, output logic conv,
                         output int iters, output logic [15:0] maxd);
        int stable = 0;
        int m, d;
        conv = 1'b0; iters = 0; maxd = '0;
        if (mi == 0) return;
        for (int it = 1; it < MAXS; it++) begin
            m = 0;
            for (int n = 0; n < N; n++) begin
                d = int'(seq[it][n]) - int'(seq[it-1][n]);
                if (d < 0) d = -d;
                if (d > m) m = d;
            end
            iters = it;
            maxd = 16'(m);
            stable = (m <= int'(t)) ? stable + 1 : 0;
            if (stable == CC) begin conv = 1'b1; return; end
            if (it == int'(mi)) return;
        end
    endtask
    task automatic run(input logic [15:0] t, input logic [7:0] mi, input int extra_start, input int abort_at);
        o_done = -1; o_init = -1; o_step1 = -1; o_nsteps = 0;
        o_conv = 1'bx; o_iter = 'x; o_maxd = 'x;
        bus.start = 1'b1; bus.tol = t; bus.max_iter = mi;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.tol = 16'($urandom); bus.max_iter = 8'($urandom);
        for (int c = 1; c < 200; c++) begin
            if (bus.dp_init && o_init < 0) o_init = c;
            if (bus.dp_step) begin
                if (o_nsteps == 0) o_step1 = c;
                o_nsteps++;
            end
            bus.start = (c == extra_start);
            bus.abort = (c == abort_at);
            if (bus.done) begin
                o_done = c; o_conv = bus.converged; o_iter = bus.iter_count; o_maxd = bus.max_delta;
                break;
            end
            if (!bus.busy) break;
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask
    task automatic verify(input string nm, input logic conv, input int iters, input logic [15:0] maxd);
        check({nm, " done_cycle"}, o_done, 3 + DP_LAT + iters * (1 + DP_LAT + N));
        check({nm, " converged"}, o_conv, conv);
        check({nm, " iter_count"}, o_iter, iters);
        check({nm, " max_delta"}, o_maxd, maxd);
        check({nm, " init_cycle"}, o_init, 1);
        check({nm, " steps"}, o_nsteps, iters);
        if (iters > 0) check({nm, " first_step"}, o_step1, 3 + DP_LAT);
        @(posedge clk); #1;
        check({nm, " done_width"}, {bus.busy, bus.done}, 2'b00);
        check({nm, " hold_conv"}, bus.converged, conv);
        check({nm, " hold_iter"}, bus.iter_count, iters);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end
    initial begin
        logic e_conv;
        int e_iters;
        logic [15:0] e_maxd, t;
        logic [7:0] mi;
        tbl[0] = '{0, 16'h0000, 8'd10, -1, 1'b1, 2, 16'h0000};
        tbl[1] = '{1, 16'h00FF, 8'd5,  -1, 1'b0, 5, 16'h0100};
        tbl[2] = '{1, 16'h0100, 8'd5,  -1, 1'b1, 2, 16'h0100};
        tbl[3] = '{0, 16'h0000, 8'd0,  -1, 1'b0, 0, 16'h0000};
        tbl[4] = '{0, 16'h0000, 8'd10,  7, 1'b1, 2, 16'h0000};
        tbl[5] = '{0, 16'h0000, 8'd1,  -1, 1'b0, 1, 16'h0000};
        tbl[6] = '{1, 16'h00FF, 8'd1,  -1, 1'b0, 1, 16'h0100};
        bus.start = 1'b0; bus.abort = 1'b0; bus.tol = '0; bus.max_iter = '0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {bus.busy, bus.done, bus.dp_init, bus.dp_step, bus.converged},  5'b0);
        check("reset iter/maxd", {bus.iter_count, bus.max_delta}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            fill(tbl[i].mode);
            run(tbl[i].tol, tbl[i].mi, tbl[i].extra_start, -1);
            verify($sformatf("vec%0d", i), tbl[i].conv, tbl[i].iters, tbl[i].maxd);
        end
        // abort during CHECK of iteration 1, then a normal run
        fill(0);
        run(16'h0000, 8'd10, -1, 7);
        check("abort no_done", o_done, -1);
        check("abort state", {bus.busy, bus.done, bus.converged, bus.dp_step}, 4'b0);
        check("abort iter", bus.iter_count, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort idle", {bus.busy, bus.done}, 2'b00);
        end
        run(16'h0000, 8'd10, -1, -1);
        verify("after_abort", 1'b1, 2, 16'h0000);
        // asynchronous reset in the STEP cycle of iteration 4
        fill(1);
        bus.start = 1'b1; bus.tol = 16'h00FF; bus.max_iter = 8'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("pre_reset step", bus.dp_step, 1'b1);
        check("pre_reset iter", bus.iter_count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset outputs", {bus.busy, bus.done, bus.dp_init, bus.dp_step, bus.converged}, 5'b0);
        check("midrun reset iter", bus.iter_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset idle", bus.busy, 1'b0);
        fill(0);
        run(16'h0000, 8'd10, -1, -1);
        verify("after_reset", 1'b1, 2, 16'h0000);
        // randomized datapath trajectories against the reference model
        for (int r = 0; r < 12; r++) begin
            spread = $urandom_range(0, 64);
            fill(2);
            t = 16'($urandom_range(0, 64));
            mi = 8'($urandom_range(0, 12));
            model(t, mi, e_conv, e_iters, e_maxd);
            run(t, mi, -1, -1);
            verify($sformatf("rand%0d", r), e_conv, e_iters, e_maxd);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
